// File: rtl/gmm_out_ram_ctrl_if.sv
// Stream-in and RAM port-2 signals of the GMM output RAM controller.
// A word moves when in_valid and in_ready are both high on a clock edge; in_valid/in_data/in_last must hold until then.
interface gmm_out_ram_ctrl_if #(
  parameter int DATA_W = 256
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  logic [5:0]          ram_address2;
  logic                ram_chipselect2;
  logic                ram_write2;
  logic [DATA_W-1:0]   ram_writedata2;
  logic [DATA_W/8-1:0] ram_byteenable2;
  logic                ram_clken2;

  // master: word producer (and RAM-side observer); slave: the controller
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  ram_address2, ram_chipselect2, ram_write2, ram_writedata2,
    input  ram_byteenable2, ram_clken2
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output ram_address2, ram_chipselect2, ram_write2, ram_writedata2,
    output ram_byteenable2, ram_clken2
  );
endinterface

// File: rtl/gmm_out_ram_ctrl.sv
// Ping-pong writer for the 64-word GMM output RAM: fills one bank while the CPU drains the other,
// committing a bank on its last slot or on in_last, and stalling while the bank to be filled is still owned by the CPU.
module gmm_out_ram_ctrl #(
  parameter int DATA_W     = 256,
  parameter int BANK_DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  gmm_out_ram_ctrl_if.slave  bus,
  input  logic               release_valid,
  input  logic               release_bank,
  output logic [1:0]         bank_full,
  output logic [5:0]         bank_len0,
  output logic [5:0]         bank_len1,
  output logic               cur_bank,
  output logic               irq,
  output logic               err_release,
  output logic [1:0]         dbg_state
);

  localparam int PTR_W = $clog2(BANK_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    wr_ptr;
  logic [5:0]          addr_hold;
  logic [DATA_W-1:0]   data_hold;
  logic [5:0]          word_addr;
  logic [1:0]          full_next;
  logic                cur_full;
  logic                accept;
  logic                commit;
  logic                rel_ok;
  logic                rel_err;

  assign cur_full = bank_full[cur_bank];
  // Reset gates in_ready so nothing reaches the RAM during a reset cycle.
  assign bus.in_ready = !reset && (state == S_FILL) && !cur_full;
  assign accept   = bus.in_valid && bus.in_ready;
  assign commit   = accept && ((wr_ptr == PTR_W'(BANK_DEPTH - 1)) || bus.in_last);
  // Releases are judged against the pre-commit flags.
  assign rel_ok   = release_valid && bank_full[release_bank];
  assign rel_err  = release_valid && !bank_full[release_bank];

  always_comb begin
    full_next = bank_full;
    if (rel_ok) full_next[release_bank] = 1'b0;
    if (commit) full_next[cur_bank] = 1'b1;
  end

  always_comb begin
    word_addr = '0;
    word_addr[PTR_W] = cur_bank;
    word_addr[PTR_W-1:0] = wr_ptr;
  end

  assign bus.ram_write2      = accept;
  assign bus.ram_chipselect2 = accept;
  assign bus.ram_address2    = accept ? word_addr : addr_hold;
  assign bus.ram_writedata2  = accept ? bus.in_data : data_hold;
  assign bus.ram_byteenable2 = '1;
  assign bus.ram_clken2      = 1'b1;
  assign dbg_state           = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      cur_bank    <= 1'b0;
      bank_full   <= 2'b00;
      bank_len0   <= '0;
      bank_len1   <= '0;
      irq         <= 1'b0;
      err_release <= 1'b0;
      addr_hold   <= '0;
      data_hold   <= '0;
    end else begin
      bank_full <= full_next;
      irq       <= |full_next;
      if (rel_err) err_release <= 1'b1;

      if (accept) begin
        addr_hold <= word_addr;
        data_hold <= bus.in_data;
      end

      if (commit) begin
        if (cur_bank) bank_len1 <= 6'(wr_ptr) + 6'd1;
        else          bank_len0 <= 6'(wr_ptr) + 6'd1;
        cur_bank <= ~cur_bank;
        wr_ptr   <= '0;
      end else if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      // Disabling only takes effect on a bank boundary so a partial bank is never stranded.
      case (state)
        S_IDLE: begin
          if (enable) state <= S_FILL;
        end
        S_FILL: begin
          if (!enable && ((wr_ptr == '0 && !accept) || commit)) state <= S_IDLE;
          else if (cur_full)                                   state <= S_STALL;
        end
        S_STALL: begin
          if (!enable && wr_ptr == '0) state <= S_IDLE;
          else if (!cur_full)          state <= S_FILL;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_no_write_to_full: assert property (@(posedge clk) disable iff (reset) accept |-> !cur_full);
  a_irq_tracks_flags: assert property (@(posedge clk) disable iff (reset) irq == |bank_full);
  a_ptr_in_range:     assert property (@(posedge clk) disable iff (reset) wr_ptr <= PTR_W'(BANK_DEPTH - 1));

endmodule

// File: tb/tb_gmm_out_ram_ctrl.sv
// Directed bench for gmm_out_ram_ctrl: bank fill/commit, in_last, stall/release, same-cycle
// commit/release, release errors, enable drain and mid-fill reset.
module tb_gmm_out_ram_ctrl;
  localparam int DATA_W     = 256;
  localparam int BANK_DEPTH = 32;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset, enable, release_valid, release_bank;
  logic [1:0] bank_full, dbg_state;
  logic [5:0] bank_len0, bank_len1;
  logic cur_bank, irq, err_release;

  always #5 clk = ~clk;

  gmm_out_ram_ctrl_if #(.DATA_W(DATA_W)) bus ();

  gmm_out_ram_ctrl #(.DATA_W(DATA_W), .BANK_DEPTH(BANK_DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus),
    .release_valid(release_valid), .release_bank(release_bank),
    .bank_full(bank_full), .bank_len0(bank_len0), .bank_len1(bank_len1),
    .cur_bank(cur_bank), .irq(irq), .err_release(err_release), .dbg_state(dbg_state)
  );

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  int side_bad = 0;
  logic [5:0]        exp_q[$];
  logic [DATA_W-1:0] exp_d_q[$];
  logic [5:0]        obs_addr_q[$];
  logic [DATA_W-1:0] obs_data_q[$];
  bit                wrote;
  logic [5:0]        waddr;

  function automatic logic [DATA_W-1:0] mk_data(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  // drivers
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d, input logic last,
                           output bit w, output logic [5:0] a);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    #1;
    w = bus.ram_write2;
    a = bus.ram_address2;
    if (bus.ram_write2) begin
      obs_addr_q.push_back(bus.ram_address2);
      obs_data_q.push_back(bus.ram_writedata2);
    end
    if (bus.ram_chipselect2 !== bus.ram_write2 || bus.ram_clken2 !== 1'b1 ||
        (bus.ram_write2 && bus.ram_byteenable2 !== '1)) side_bad++;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; release_valid = 1'b0; release_bank = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = mk_data(99); bus.in_last = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.ram_write2 !== 1'b0 || bus.ram_chipselect2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_dominates: ready/write/cs=%b%b%b want 000", bus.in_ready, bus.ram_write2, bus.ram_chipselect2);
    end
    tick();
    tick();
    vectors++;
    if ({bank_full, bank_len0, bank_len1, cur_bank, irq, err_release, dbg_state} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_values: full=%b len0=%0d len1=%0d cur=%b irq=%b err=%b st=%0d want all 0",
               bank_full, bank_len0, bank_len1, cur_bank, irq, err_release, dbg_state);
    end
    reset = 1'b0; enable = 1'b0; bus.in_valid = 1'b0;
    tick();
    vectors++;
    if (dbg_state !== ST_IDLE || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: st=%0d ready=%b want 0/0", dbg_state, bus.in_ready);
    end
  endtask

  task automatic test_full_bank;
    obs_addr_q.delete(); obs_data_q.delete();
    enable = 1'b1;
    tick();
    vectors++;
    if (dbg_state !== ST_FILL || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL enter_fill: st=%0d ready=%b want 1/1", dbg_state, bus.in_ready);
    end
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(6'(i));
      exp_d_q.push_back(mk_data(i));
      push_word(mk_data(i), 1'b0, wrote, waddr);
    end
    vectors++;
    if (obs_addr_q.size() != 32) begin
      miscompares++;
      $display("FAIL full_bank_count: got %0d writes want 32", obs_addr_q.size());
    end
    while (exp_q.size() > 0 && obs_addr_q.size() > 0) begin
      logic [5:0] ea, oa;
      logic [DATA_W-1:0] ed, od;
      ea = exp_q.pop_front(); ed = exp_d_q.pop_front();
      oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front();
      vectors++;
      if (oa !== ea || od !== ed) begin
        miscompares++;
        $display("FAIL full_bank_write: addr %0d data %h want addr %0d data %h", oa, od[31:0], ea, ed[31:0]);
      end
    end
    exp_q.delete(); exp_d_q.delete();
    vectors++;
    if ({bank_full, bank_len0, cur_bank, irq} !== {2'b01, 6'd32, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL full_bank_commit: full=%b len0=%0d cur=%b irq=%b want 01/32/1/1", bank_full, bank_len0, cur_bank, irq);
    end
  endtask

  task automatic test_last_and_fill_both;
    obs_addr_q.delete(); obs_data_q.delete();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(6'(i));
      exp_d_q.push_back(mk_data(100 + i));
      push_word(mk_data(100 + i), (i == 4), wrote, waddr);
    end
    vectors++;
    if (obs_addr_q.size() != 5) begin
      miscompares++;
      $display("FAIL last_count: got %0d writes want 5", obs_addr_q.size());
    end
    while (exp_q.size() > 0 && obs_addr_q.size() > 0) begin
      logic [5:0] ea, oa;
      logic [DATA_W-1:0] ed, od;
      ea = exp_q.pop_front(); ed = exp_d_q.pop_front();
      oa = obs_addr_q.pop_front(); od = obs_data_q.pop_front();
      vectors++;
      if (oa !== ea || od !== ed) begin
        miscompares++;
        $display("FAIL last_write: addr %0d data %h want addr %0d data %h", oa, od[31:0], ea, ed[31:0]);
      end
    end
    exp_q.delete(); exp_d_q.delete();
    vectors++;
    if ({bank_full, bank_len0, cur_bank, irq} !== {2'b01, 6'd5, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL last_commit: full=%b len0=%0d cur=%b irq=%b want 01/5/1/1", bank_full, bank_len0, cur_bank, irq);
    end
    push_word(mk_data(105), 1'b0, wrote, waddr);
    vectors++;
    if (!wrote || waddr !== 6'd32) begin
      miscompares++;
      $display("FAIL next_bank_addr: wrote=%b addr=%0d want 1/32", wrote, waddr);
    end
    obs_addr_q.delete(); obs_data_q.delete();
    for (int i = 0; i < 31; i++) push_word(mk_data(106 + i), 1'b0, wrote, waddr);
    vectors++;
    if (obs_addr_q.size() != 31 || waddr !== 6'd63) begin
      miscompares++;
      $display("FAIL bank1_fill: got %0d writes last addr %0d want 31/63", obs_addr_q.size(), waddr);
    end
    vectors++;
    if ({bank_full, bank_len1, cur_bank, bus.in_ready} !== {2'b11, 6'd32, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL both_full: full=%b len1=%0d cur=%b ready=%b want 11/32/0/0", bank_full, bank_len1, cur_bank, bus.in_ready);
    end
  endtask

  task automatic test_stall_release;
    bus.in_valid = 1'b1; bus.in_data = mk_data(200);
    #1;
    vectors++;
    if (bus.ram_write2 !== 1'b0) begin
      miscompares++;
      $display("FAIL no_write_full: write=%b want 0", bus.ram_write2);
    end
    tick();
    vectors++;
    if (dbg_state !== ST_STALL || bus.in_ready !== 1'b0 || bus.ram_write2 !== 1'b0) begin
      miscompares++;
      $display("FAIL stall: st=%0d ready=%b write=%b want 2/0/0", dbg_state, bus.in_ready, bus.ram_write2);
    end
    release_valid = 1'b1; release_bank = 1'b0;
    tick();
    release_valid = 1'b0;
    #1;
    vectors++;
    if (bank_full !== 2'b10 || bus.in_ready !== 1'b0 || bus.ram_write2 !== 1'b0) begin
      miscompares++;
      $display("FAIL release_plus1: full=%b ready=%b write=%b want 10/0/0", bank_full, bus.in_ready, bus.ram_write2);
    end
    tick();
    vectors++;
    if (dbg_state !== ST_FILL || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL release_plus2: st=%0d ready=%b want 1/1", dbg_state, bus.in_ready);
    end
    push_word(mk_data(201), 1'b0, wrote, waddr);
    vectors++;
    if (!wrote || waddr !== 6'd0) begin
      miscompares++;
      $display("FAIL resume_addr: wrote=%b addr=%0d want 1/0", wrote, waddr);
    end
  endtask

  task automatic test_cross_commit;
    push_word(mk_data(202), 1'b1, wrote, waddr);
    vectors++;
    if (!wrote || waddr !== 6'd1 || {bank_full, bank_len0, cur_bank} !== {2'b11, 6'd2, 1'b1}) begin
      miscompares++;
      $display("FAIL short_commit: addr=%0d full=%b len0=%0d cur=%b want 1/11/2/1", waddr, bank_full, bank_len0, cur_bank);
    end
    release_valid = 1'b1; release_bank = 1'b1;
    tick();
    release_valid = 1'b0;
    vectors++;
    if (bank_full !== 2'b01 || dbg_state !== ST_STALL) begin
      miscompares++;
      $display("FAIL release_bank1: full=%b st=%0d want 01/2", bank_full, dbg_state);
    end
    tick();
    release_valid = 1'b1; release_bank = 1'b0;
    push_word(mk_data(203), 1'b1, wrote, waddr);
    release_valid = 1'b0;
    vectors++;
    if (!wrote || waddr !== 6'd32) begin
      miscompares++;
      $display("FAIL cross_write: wrote=%b addr=%0d want 1/32", wrote, waddr);
    end
    vectors++;
    if ({bank_full, bank_len0, bank_len1, cur_bank, irq, err_release} !== {2'b10, 6'd2, 6'd1, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL cross_commit: full=%b len0=%0d len1=%0d cur=%b irq=%b err=%b want 10/2/1/0/1/0",
               bank_full, bank_len0, bank_len1, cur_bank, irq, err_release);
    end
  endtask

  task automatic test_err_release;
    release_valid = 1'b1; release_bank = 1'b1;
    tick();
    release_valid = 1'b0;
    vectors++;
    if ({bank_full, irq, err_release} !== 4'b0000) begin
      miscompares++;
      $display("FAIL drain_all: full=%b irq=%b err=%b want 00/0/0", bank_full, irq, err_release);
    end
    release_valid = 1'b1; release_bank = 1'b1;
    push_word(mk_data(204), 1'b0, wrote, waddr);
    release_valid = 1'b0;
    vectors++;
    if (!wrote || waddr !== 6'd0 || bank_full !== 2'b00 || err_release !== 1'b1) begin
      miscompares++;
      $display("FAIL bad_release: wrote=%b addr=%0d full=%b err=%b want 1/0/00/1", wrote, waddr, bank_full, err_release);
    end
    release_valid = 1'b1; release_bank = 1'b0;
    push_word(mk_data(205), 1'b1, wrote, waddr);
    release_valid = 1'b0;
    vectors++;
    if (waddr !== 6'd1 || {bank_full, bank_len0, cur_bank, err_release} !== {2'b01, 6'd2, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL commit_wins: addr=%0d full=%b len0=%0d cur=%b err=%b want 1/01/2/1/1",
               waddr, bank_full, bank_len0, cur_bank, err_release);
    end
  endtask

  task automatic test_enable_drain;
    enable = 1'b0;
    push_word(mk_data(206), 1'b0, wrote, waddr);
    vectors++;
    if (!wrote || waddr !== 6'd32 || dbg_state !== ST_FILL) begin
      miscompares++;
      $display("FAIL drain_continue: wrote=%b addr=%0d st=%0d want 1/32/1", wrote, waddr, dbg_state);
    end
    push_word(mk_data(207), 1'b1, wrote, waddr);
    vectors++;
    if (waddr !== 6'd33 || dbg_state !== ST_IDLE || bus.in_ready !== 1'b0 ||
        {bank_full, bank_len1, cur_bank} !== {2'b11, 6'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL drain_idle: addr=%0d st=%0d ready=%b full=%b len1=%0d cur=%b want 33/0/0/11/2/0",
               waddr, dbg_state, bus.in_ready, bank_full, bank_len1, cur_bank);
    end
  endtask

  task automatic test_reset_mid_fill;
    release_valid = 1'b1; release_bank = 1'b0;
    tick();
    release_bank = 1'b1;
    tick();
    release_valid = 1'b0;
    enable = 1'b1;
    tick();
    obs_addr_q.delete(); obs_data_q.delete();
    for (int i = 0; i < 10; i++) push_word(mk_data(300 + i), 1'b0, wrote, waddr);
    vectors++;
    if (obs_addr_q.size() != 10 || waddr !== 6'd9 || err_release !== 1'b1) begin
      miscompares++;
      $display("FAIL partial_fill: got %0d writes last addr %0d err=%b want 10/9/1", obs_addr_q.size(), waddr, err_release);
    end
    reset = 1'b1; bus.in_valid = 1'b1;
    #1;
    vectors++;
    if (bus.ram_write2 !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midfill_reset_gate: write=%b ready=%b want 0/0", bus.ram_write2, bus.in_ready);
    end
    tick();
    vectors++;
    if ({bank_full, bank_len0, bank_len1, cur_bank, irq, err_release, dbg_state} !== 21'd0) begin
      miscompares++;
      $display("FAIL midfill_reset: full=%b len0=%0d len1=%0d cur=%b irq=%b err=%b st=%0d want all 0",
               bank_full, bank_len0, bank_len1, cur_bank, irq, err_release, dbg_state);
    end
    reset = 1'b0; bus.in_valid = 1'b0;
    tick();
    push_word(mk_data(400), 1'b0, wrote, waddr);
    vectors++;
    if (!wrote || waddr !== 6'd0) begin
      miscompares++;
      $display("FAIL restart_addr: wrote=%b addr=%0d want 1/0", wrote, waddr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_full_bank();
    test_reset();
    test_last_and_fill_both();
    test_stall_release();
    test_cross_commit();
    test_err_release();
    test_enable_drain();
    test_reset_mid_fill();
    vectors++;
    if (side_bad != 0) begin
      miscompares++;
      $display("FAIL ram_side_signals: %0d bad cycles want 0", side_bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gmm_out_ram_ctrl.md
GMM_OUT_RAM_CTRL -- requirements
Module: gmm_out_ram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 256, meaning stream and RAM word width.
REQ-002 SHALL have parameter BANK_DEPTH, default 32, meaning words per ping-pong bank; two banks fill the 64-word GMM output RAM.
REQ-003 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  capture enable
- in_valid  in  1  GMM result word valid
- in_data  in  DATA_W  GMM result word
- in_last  in  1  last word of frame segment
- in_ready  out  1  controller accepts word
- release_valid  in  1  CPU releases a bank
- release_bank  in  1  bank index being released
- ram_address2  out  6  RAM port-2 address
- ram_chipselect2  out  1  RAM port-2 select
- ram_write2  out  1  RAM port-2 write
- ram_writedata2  out  DATA_W  RAM port-2 data
- ram_byteenable2  out  DATA_W/8  RAM port-2 byte enables
- ram_clken2  out  1  RAM port-2 clock enable
- bank_full  out  2  per-bank "ready for CPU" flags
- bank_len0  out  6  committed word count, bank 0 (1..32)
- bank_len1  out  6  committed word count, bank 1 (1..32)
- cur_bank  out  1  bank currently filling
- irq  out  1  level interrupt
- err_release  out  1  sticky error: release of a non-full bank

Function
REQ-005 SHALL implement states IDLE, FILL, STALL.
REQ-006 IDLE: in_ready=0; move to FILL on enable=1.
REQ-007 FILL: in_ready=1 iff bank_full[cur_bank]=0.
REQ-008 FILL: move to STALL when bank_full[cur_bank]=1.
REQ-009 STALL: in_ready=0; return to FILL the cycle after bank_full[cur_bank] clears.
REQ-010 enable=0 in FILL or STALL: return to IDLE only when wr_ptr=0; otherwise finish the current bank first.
REQ-011 Accept = in_valid & in_ready. ram_write2 and ram_chipselect2 SHALL equal accept combinationally, in the same cycle.
REQ-012 On accept: ram_address2={cur_bank, wr_ptr[4:0]}, ram_writedata2=in_data, ram_byteenable2=all ones.
REQ-013 ram_clken2 SHALL be constant 1.
REQ-014 When no accept occurs, ram_address2 and ram_writedata2 SHALL hold their values; do-not-care for checking.
REQ-015 On accept, wr_ptr SHALL increment modulo BANK_DEPTH.
REQ-016 Commit occurs on an accept with wr_ptr=BANK_DEPTH-1 or in_last=1. On commit, next cycle:
- bank_full[cur_bank]=1
- bank_len of that bank = wr_ptr+1
- cur_bank toggles
- wr_ptr=0
REQ-017 Write-to-readable latency: data is in RAM and bank_full is visible one cycle after the committing accept.
REQ-018 On release_valid with bank_full[release_bank]=1: clear that flag next cycle; bank_len is retained.
REQ-019 On release_valid with bank_full[release_bank]=0: ignore the release and set err_release (sticky until reset).
REQ-020 Simultaneous commit and release of the same bank in one cycle: the release sees the pre-commit flag value. Flag result = 1 if the flag was 0 (release ignored, err set). Commit SHALL win.
REQ-021 Simultaneous commit of one bank and release of the other: both take effect in the same cycle.
REQ-022 irq SHALL equal |bank_full, registered.
REQ-023 There SHALL be no data loss: words are never written into a bank whose flag is set.

Reset
REQ-024 reset SHALL dominate all other inputs in the same cycle.
REQ-025 Reset values:
- state=IDLE, wr_ptr=0, cur_bank=0
- bank_full=00, bank_len0=bank_len1=0
- irq=0, err_release=0, in_ready=0
- ram_write2=0, ram_chipselect2=0
REQ-026 Reset mid-fill SHALL discard the partial bank; the RAM contents are not cleared.

Verification
REQ-027 Enable, stream 32 words D0..D31 with no backpressure -> 32 writes to addresses 0..31; next cycle bank_full=01, bank_len0=32, cur_bank=1, irq=1.
REQ-028 Stream 5 words with in_last on the 5th -> addresses 0..4; bank_full=01, bank_len0=5; the next word goes to address 32.
REQ-029 Fill both banks with no release -> in_ready=0 and state STALL; release bank 0 -> in_ready=1 two cycles later, and writes resume at address 0.
REQ-030 Release bank 1 while bank_full=00 -> err_release=1, bank_full unchanged, streaming unaffected.
REQ-031 Same cycle: commit bank 1 and release bank 0 -> next cycle bank_full=10.
REQ-032 Assert reset after 10 words in bank 0 -> all outputs at reset values next cycle; after re-enable, the first write goes to address 0.
